m_ex_queue: RTL

M_EX_QUEUE -- requirements
Module: m_ex_queue

---
 rtl/m_ex_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/m_ex_queue.sv
// In-order M-to-EX issue queue: 8-slot circular FIFO whose occupied slots can be
// rewritten in place by M-stage modifier logic; the head issues once it is valid and fully woken.
module m_ex_queue #(
   parameter int MSIZE = 780,
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 flush,
   input  logic                 enq_valid,
   input  logic [MSIZE-1:0]     enq_entry,
   output logic                 enq_ready,
   output logic                 deq_valid,
   output logic [MSIZE-1:0]     deq_entry,
   input  logic                 deq_ready,
   output logic [8*MSIZE-1:0]   old_m_M_EX,
   input  logic [8*MSIZE-1:0]   new_m_M_EX,
   input  logic [7:0]           modify_M_EX_latch,
   output logic [3:0]           occupancy,
   output logic [2:0]           head_ptr
);

   logic [2:0]       head_q, head_d;
   logic [2:0]       tail_q, tail_d;
   logic [3:0]       count_q, count_d;
   logic [MSIZE-1:0] head_entry;
   logic [3:0]       head_wake;
   logic             do_enq;
   logic             do_deq;

   // deq_entry is the raw head slot; modifier updates only become visible next cycle
   assign head_entry = old_m_M_EX[MSIZE*head_q +: MSIZE];
   assign head_wake  = head_entry[MSIZE-8 -: 4];

   assign enq_ready  = (count_q < 4'(DEPTH));
   assign deq_valid  = (count_q != 4'd0) && head_entry[0] && (head_wake == 4'b1111);
   assign deq_entry  = head_entry;
   assign occupancy  = count_q;
   assign head_ptr   = head_q;

   assign do_enq = enq_valid && enq_ready;
   assign do_deq = deq_valid && deq_ready;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         logic [MSIZE-1:0] slot_q, slot_d;
         logic [2:0]       offset;
         logic             occupied;

         // A slot is live when its distance from head is below the count
         assign offset   = 3'(gi) - head_q;
         assign occupied = ({1'b0, offset} < count_q);

         always_comb begin
            slot_d = slot_q;
            if (flush)
               slot_d = '0;
            else if (do_deq && (head_q == 3'(gi)))
               slot_d = '0;
            else if (do_enq && (tail_q == 3'(gi)))
               slot_d = enq_entry | MSIZE'(1);
            else if (modify_M_EX_latch[gi] && occupied)
               slot_d = new_m_M_EX[MSIZE*gi +: MSIZE];
         end

         always_ff @(posedge clk or negedge clr) begin
            if (!clr)
               slot_q <= '0;
            else
               slot_q <= slot_d;
         end

         assign old_m_M_EX[MSIZE*gi +: MSIZE] = slot_q;
      end
   endgenerate

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = 3'd0;
         tail_d  = 3'd0;
         count_d = 4'd0;
      end else begin
         if (do_enq) tail_d = tail_q + 3'd1;
         if (do_deq) head_d = head_q + 3'd1;
         if (do_enq && !do_deq)
            count_d = count_q + 4'd1;
         else if (!do_enq && do_deq)
            count_d = count_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         head_q  <= 3'd0;
         tail_q  <= 3'd0;
         count_q <= 4'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule
